// File: rtl/prewitt_frame_ctrl_pkg.sv
// Shared types for the Prewitt frame sequencer: state encoding, window tag and counter width.
package prewitt_frame_ctrl_pkg;

    localparam int CNT_W = 11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic valid;
        logic sof;
        logic eof;
    } tag_t;

endpackage

// File: rtl/prewitt_tag_pipe.sv
// LAT-deep window tag shift register, advancing only on datapath valid_in edges; sync clear drops in-flight tags.
// o_fresh marks the cycle after stage LAT-1 was loaded; no backpressure, holds on gaps.
module prewitt_tag_pipe
    import prewitt_frame_ctrl_pkg::*;
#(
    parameter int LAT = 3
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    input  logic i_clr,
    input  tag_t i_tag,
    output tag_t o_tag,
    output logic o_fresh
);
    tag_t [LAT-1:0] r_pipe;
    logic           r_fresh;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pipe  <= '0;
            r_fresh <= 1'b0;
        end else if (i_clr) begin
            r_pipe  <= '0;
            r_fresh <= 1'b0;
        end else begin
            r_fresh <= i_en;
            if (i_en) begin
                r_pipe <= {r_pipe[LAT-2:0], i_tag};
            end
        end
    end

    assign o_tag   = r_pipe[LAT-1];
    assign o_fresh = r_fresh;

endmodule

// File: rtl/prewitt_frame_ctrl.sv
// Raster sequencer for the 3x3 Prewitt datapath: counts pixels, drives valid_in, flushes at end of frame.
// Sideband trails acceptance by LAT valid_in edges; in_ready drops for FLUSH/DONE so the source holds.
module prewitt_frame_ctrl
    import prewitt_frame_ctrl_pkg::*;
#(
    parameter logic [CNT_W-1:0] PIC_WIDTH  = 11'd250,
    parameter logic [CNT_W-1:0] PIC_HEIGHT = 11'd250,
    parameter int               LAT        = 3
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_pix_valid,
    input  logic             i_pix_sof,
    output logic             o_in_ready,
    output logic             o_mat_valid,
    output logic             o_flush,
    output logic [CNT_W-1:0] o_x_cnt,
    output logic [CNT_W-1:0] o_y_cnt,
    output logic             o_out_valid,
    output logic             o_out_sof,
    output logic             o_out_eof,
    output logic             o_frame_done,
    output logic             o_err_sof
);
    localparam int            FW         = $clog2(LAT);
    localparam logic [FW-1:0] FLUSH_LOAD = FW'(LAT - 2);

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_x, r_y, w_x_nxt, w_y_nxt;
    logic [FW-1:0]    r_fcnt, w_fcnt_nxt;
    logic             r_in_ready, r_flush, r_frame_done, r_err_sof;
    logic             w_accept, w_pix, w_run_pix, w_restart, w_x_last, w_y_last, w_mat_valid;
    logic             w_fresh;
    tag_t             w_tag, w_tag_out;

    always_comb begin
        w_accept    = i_pix_valid & r_in_ready;
        w_x_last    = (r_x == PIC_WIDTH - 1'b1);
        w_y_last    = (r_y == PIC_HEIGHT - 1'b1);
        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_fcnt_nxt  = r_fcnt;
        w_pix       = 1'b0;
        w_run_pix   = 1'b0;
        w_restart   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && i_pix_sof) begin
                    w_state_nxt = ST_RUN;
                    w_pix       = 1'b1;
                    w_x_nxt     = CNT_W'(1);
                    w_y_nxt     = '0;
                end
            end
            ST_RUN: begin
                if (w_accept) begin
                    w_pix = 1'b1;
                    if (i_pix_sof) begin
                        // Mid-frame SOF: abandon the partial frame, this pixel becomes (0,0).
                        w_restart = 1'b1;
                        w_x_nxt   = CNT_W'(1);
                        w_y_nxt   = '0;
                    end else begin
                        w_run_pix = 1'b1;
                        if (w_x_last) begin
                            w_x_nxt = '0;
                            if (w_y_last) begin
                                w_y_nxt     = '0;
                                w_state_nxt = ST_FLUSH;
                                w_fcnt_nxt  = FLUSH_LOAD;
                            end else begin
                                w_y_nxt = r_y + 1'b1;
                            end
                        end else begin
                            w_x_nxt = r_x + 1'b1;
                        end
                    end
                end
            end
            ST_FLUSH: begin
                if (r_fcnt == '0) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_fcnt_nxt = r_fcnt - 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        w_mat_valid = w_pix | (r_state == ST_FLUSH);
        w_tag       = '0;
        w_tag.valid = w_run_pix & (r_x >= CNT_W'(2)) & (r_y >= CNT_W'(2));
        w_tag.sof   = w_run_pix & (r_x == CNT_W'(2)) & (r_y == CNT_W'(2));
        w_tag.eof   = w_run_pix & w_x_last & w_y_last;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_x          <= '0;
            r_y          <= '0;
            r_fcnt       <= '0;
            r_in_ready   <= 1'b1;
            r_flush      <= 1'b0;
            r_frame_done <= 1'b0;
            r_err_sof    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_x          <= w_x_nxt;
            r_y          <= w_y_nxt;
            r_fcnt       <= w_fcnt_nxt;
            r_in_ready   <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_RUN);
            r_flush      <= (w_state_nxt == ST_FLUSH);
            r_frame_done <= (w_state_nxt == ST_DONE);
            r_err_sof    <= r_err_sof | w_restart;
        end
    end

    prewitt_tag_pipe #(
        .LAT (LAT)
    ) u_tag_pipe (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (w_mat_valid),
        .i_clr   (w_restart),
        .i_tag   (w_tag),
        .o_tag   (w_tag_out),
        .o_fresh (w_fresh)
    );

    // Sideband is a flop-to-flop AND: the tag in the last stage qualified by "loaded on the previous edge".
    assign o_out_valid  = w_fresh & w_tag_out.valid;
    assign o_out_sof    = w_fresh & w_tag_out.sof;
    assign o_out_eof    = w_fresh & w_tag_out.eof;
    assign o_in_ready   = r_in_ready;
    assign o_mat_valid  = w_mat_valid;
    assign o_flush      = r_flush;
    assign o_x_cnt      = r_x;
    assign o_y_cnt      = r_y;
    assign o_frame_done = r_frame_done;
    assign o_err_sof    = r_err_sof;

endmodule

// File: tb/tb_prewitt_frame_ctrl.sv
// Self-checking bench for prewitt_frame_ctrl on a 5x4 frame with LAT=3.
module tb_prewitt_frame_ctrl;
    import prewitt_frame_ctrl_pkg::*;

    localparam int W    = 5;
    localparam int H    = 4;
    localparam int LAT  = 3;
    localparam int NPIX = W * H;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             pix_valid, pix_sof;
    logic             in_ready, mat_valid, flush, out_valid, out_sof, out_eof, frame_done, err_sof;
    logic [CNT_W-1:0] x_cnt, y_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: frame position as a pixel index, plus a history of valid_in tags.
    int         m_mode, m_pos, m_fl;
    logic       m_err;
    logic [2:0] m_out;
    logic [2:0] m_hist[$];

    int          st_pulses, st_first, st_sof_n, st_eof_n, st_eof_cnt, st_flush, st_done;
    int          st_matv, st_xy_nz, st_ir0, st_last_acc, st_sof_acc, st_gap_p, st_mm, st_mm_cyc;
    logic        st_in_gap, last_acc;
    logic [29:0] st_mm_got, st_mm_exp;

    always #5 clk = ~clk;

    prewitt_frame_ctrl #(
        .PIC_WIDTH  (11'd5),
        .PIC_HEIGHT (11'd4),
        .LAT        (LAT)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_pix_valid  (pix_valid),
        .i_pix_sof    (pix_sof),
        .o_in_ready   (in_ready),
        .o_mat_valid  (mat_valid),
        .o_flush      (flush),
        .o_x_cnt      (x_cnt),
        .o_y_cnt      (y_cnt),
        .o_out_valid  (out_valid),
        .o_out_sof    (out_sof),
        .o_out_eof    (out_eof),
        .o_frame_done (frame_done),
        .o_err_sof    (err_sof)
    );

    task automatic model_reset();
        m_mode = 0; m_pos = 0; m_fl = 0; m_err = 1'b0; m_out = 3'b000;
        m_hist.delete();
    endtask

    task automatic clr_stats();
        st_pulses = 0; st_first = -1; st_sof_n = 0; st_eof_n = 0; st_eof_cnt = 0; st_flush = 0;
        st_done = -1; st_matv = 0; st_xy_nz = 0; st_ir0 = 0; st_last_acc = -1; st_sof_acc = -1;
        st_gap_p = 0; st_mm = 0; st_mm_cyc = -1; st_in_gap = 1'b0; st_mm_got = '0; st_mm_exp = '0;
    endtask

    // One clock cycle: drive inputs, sample outputs against the model, advance the model.
    task automatic drive_cycle(input logic v, input logic s);
        logic        e_rdy, e_acc, e_mv, restart;
        logic [2:0]  t;
        logic [29:0] got, exp;
        @(negedge clk);
        pix_valid = v;
        pix_sof   = s;
        #1;
        e_rdy = (m_mode <= 1);
        e_acc = e_rdy & v;
        e_mv  = (e_acc & ((m_mode == 1) | s)) | (m_mode == 2);
        exp = {e_rdy, e_mv, m_mode == 2, 11'(m_pos % W), 11'(m_pos / W), m_out, m_mode == 3, m_err};
        got = {in_ready, mat_valid, flush, x_cnt, y_cnt, out_valid, out_sof, out_eof, frame_done, err_sof};
        if (got !== exp) begin
            if (st_mm == 0) begin st_mm_got = got; st_mm_exp = exp; st_mm_cyc = cyc; end
            st_mm++;
        end
        if (out_valid) begin
            st_pulses++;
            if (st_first < 0) st_first = cyc;
            if (out_sof) st_sof_n = st_pulses;
            if (out_eof) begin st_eof_n = st_pulses; st_eof_cnt++; end
            if (st_in_gap) st_gap_p++;
        end
        if (flush) st_flush++;
        if (frame_done) st_done = cyc;
        if (mat_valid) st_matv++;
        if (x_cnt != 0 || y_cnt != 0) st_xy_nz++;
        if (!in_ready) st_ir0++;
        last_acc = in_ready & pix_valid;
        if (last_acc) begin
            st_last_acc = cyc;
            if (pix_sof) st_sof_acc = cyc;
        end
        @(posedge clk);
        cyc++;
        restart = e_acc && s && (m_mode == 1);
        t = 3'b000;
        if (e_acc && m_mode == 1 && !s)
            t = {(m_pos % W) >= 2 && (m_pos / W) >= 2, (m_pos % W) == 2 && (m_pos / W) == 2, m_pos == NPIX - 1};
        m_out = 3'b000;
        if (e_mv) begin
            m_hist.push_back(t);
            if (restart) m_hist.delete();
            else if (m_hist.size() >= LAT) m_out = m_hist[m_hist.size() - LAT];
            while (m_hist.size() > LAT) void'(m_hist.pop_front());
        end
        case (m_mode)
            0: if (e_acc && s) begin m_mode = 1; m_pos = 1; end
            1: if (e_acc) begin
                   if (s) begin m_pos = 1; m_err = 1'b1; end
                   else if (m_pos == NPIX - 1) begin m_mode = 2; m_pos = 0; m_fl = LAT - 1; end
                   else m_pos++;
               end
            2: begin m_fl--; if (m_fl == 0) m_mode = 3; end
            default: m_mode = 0;
        endcase
    endtask

    task automatic send_pixels(input int first, input int last, input int gap_idx, input int gap_len);
        for (int p = first; p <= last; p++) begin
            drive_cycle(1'b1, p == 0);
            if (p == gap_idx) begin
                st_in_gap = 1'b1;
                repeat (gap_len) drive_cycle(1'b0, 1'b0);
                st_in_gap = 1'b0;
            end
        end
    endtask

    task automatic drain();
        repeat (LAT + 2) drive_cycle(1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; pix_valid = 1'b0; pix_sof = 1'b0;
        model_reset();
        #12;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        n_checks++; if (mat_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mat_valid: got %b want 0", mat_valid); end
        n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL rst_flush: got %b want 0", flush); end
        n_checks++; if (x_cnt !== 11'd0 || y_cnt !== 11'd0) begin n_fail++; $display("FAIL rst_xy: got %0d,%0d want 0,0", x_cnt, y_cnt); end
        n_checks++; if ({out_valid, out_sof, out_eof} !== 3'b000) begin n_fail++; $display("FAIL rst_out: got %b want 000", {out_valid, out_sof, out_eof}); end
        n_checks++; if (frame_done !== 1'b0 || err_sof !== 1'b0) begin n_fail++; $display("FAIL rst_done_err: got %b%b want 00", frame_done, err_sof); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_continuous();
        clr_stats();
        send_pixels(0, NPIX - 1, -1, 0);
        drain();
        n_checks++; if (st_mm !== 0) begin n_fail++; $display("FAIL cont_model: %0d cycles differ, first cyc %0d got %h want %h", st_mm, st_mm_cyc, st_mm_got, st_mm_exp); end
        n_checks++; if (st_pulses !== 6) begin n_fail++; $display("FAIL cont_pulses: got %0d want 6", st_pulses); end
        n_checks++; if (st_sof_n !== 1 || st_eof_n !== 6) begin n_fail++; $display("FAIL cont_sof_eof: got pulse %0d/%0d want 1/6", st_sof_n, st_eof_n); end
        n_checks++; if (st_flush !== 2) begin n_fail++; $display("FAIL cont_flush: got %0d cycles want 2", st_flush); end
        n_checks++; if (st_done - st_last_acc !== 3) begin n_fail++; $display("FAIL cont_done: got T+%0d want T+3", st_done - st_last_acc); end
        n_checks++; if (st_first - st_sof_acc !== 15) begin n_fail++; $display("FAIL cont_latency: got %0d want 15", st_first - st_sof_acc); end
    endtask

    task automatic test_gap();
        clr_stats();
        send_pixels(0, NPIX - 1, 2 * W + 3, 4);
        drain();
        n_checks++; if (st_mm !== 0) begin n_fail++; $display("FAIL gap_model: %0d cycles differ, first cyc %0d got %h want %h", st_mm, st_mm_cyc, st_mm_got, st_mm_exp); end
        n_checks++; if (st_pulses !== 6) begin n_fail++; $display("FAIL gap_pulses: got %0d want 6", st_pulses); end
        n_checks++; if (st_gap_p !== 0) begin n_fail++; $display("FAIL gap_quiet: got %0d pulses in gap want 0", st_gap_p); end
        n_checks++; if (st_first - st_sof_acc !== 19) begin n_fail++; $display("FAIL gap_shift: got %0d want 19", st_first - st_sof_acc); end
    endtask

    task automatic test_idle_no_sof();
        clr_stats();
        repeat (6) drive_cycle(1'b1, 1'b0);
        n_checks++; if (st_matv !== 0) begin n_fail++; $display("FAIL idle_mat_valid: got %0d edges want 0", st_matv); end
        n_checks++; if (st_xy_nz !== 0) begin n_fail++; $display("FAIL idle_counters: got %0d nonzero cycles want 0", st_xy_nz); end
        n_checks++; if (st_pulses !== 0 || st_mm !== 0) begin n_fail++; $display("FAIL idle_outputs: got %0d pulses %0d diffs want 0 0", st_pulses, st_mm); end
    endtask

    task automatic test_sof_restart();
        clr_stats();
        for (int p = 0; p <= W + 2; p++) drive_cycle(1'b1, p == 0 || p == W + 2);
        send_pixels(1, NPIX - 1, -1, 0);
        drain();
        #1;
        n_checks++; if (err_sof !== 1'b1) begin n_fail++; $display("FAIL restart_err: got %b want 1", err_sof); end
        n_checks++; if (st_pulses !== 6 || st_sof_n !== 1 || st_eof_n !== 6) begin n_fail++; $display("FAIL restart_pulses: got %0d sof@%0d eof@%0d want 6 1 6", st_pulses, st_sof_n, st_eof_n); end
        clr_stats();
        for (int p = 0; p <= 2 * W + 4; p++) drive_cycle(1'b1, p == 0 || p == 2 * W + 4);
        send_pixels(1, NPIX - 1, -1, 0);
        drain();
        n_checks++; if (st_pulses !== 6 || st_first - st_sof_acc !== 15) begin n_fail++; $display("FAIL restart_clear: got %0d pulses first +%0d want 6 +15", st_pulses, st_first - st_sof_acc); end
        n_checks++; if (st_mm !== 0) begin n_fail++; $display("FAIL restart_model: %0d cycles differ, first cyc %0d got %h want %h", st_mm, st_mm_cyc, st_mm_got, st_mm_exp); end
    endtask

    task automatic test_reset_in_flush();
        clr_stats();
        send_pixels(0, NPIX - 1, -1, 0);
        drive_cycle(1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++; if (st_flush !== 1) begin n_fail++; $display("FAIL rif_in_flush: got %0d flush cycles want 1", st_flush); end
        n_checks++; if ({in_ready, flush, mat_valid} !== 3'b100) begin n_fail++; $display("FAIL rif_ctrl: got %b want 100", {in_ready, flush, mat_valid}); end
        n_checks++; if ({out_valid, out_eof, frame_done, err_sof} !== 4'b0000 || x_cnt !== 11'd0 || y_cnt !== 11'd0) begin n_fail++; $display("FAIL rif_state: got %b x%0d y%0d want 0000 x0 y0", {out_valid, out_eof, frame_done, err_sof}, x_cnt, y_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
        clr_stats();
        send_pixels(0, NPIX - 1, -1, 0);
        drain();
        n_checks++; if (st_pulses !== 6 || st_eof_n !== 6 || st_mm !== 0) begin n_fail++; $display("FAIL rif_next_frame: got %0d pulses eof@%0d %0d diffs want 6 6 0", st_pulses, st_eof_n, st_mm); end
    endtask

    task automatic test_back_to_back();
        int   t_last;
        logic got_acc;
        clr_stats();
        send_pixels(0, NPIX - 1, -1, 0);
        t_last  = st_last_acc;
        st_ir0  = 0;
        got_acc = 1'b0;
        for (int i = 0; i < 8 && !got_acc; i++) begin
            drive_cycle(1'b1, 1'b1);
            got_acc = last_acc;
        end
        n_checks++; if (got_acc !== 1'b1) begin n_fail++; $display("FAIL b2b_accept: got %b want 1 within 8 cycles", got_acc); end
        n_checks++; if (st_ir0 !== 3) begin n_fail++; $display("FAIL b2b_stall: got %0d cycles want 3", st_ir0); end
        n_checks++; if (st_sof_acc - t_last !== 4) begin n_fail++; $display("FAIL b2b_start: got T+%0d want T+4", st_sof_acc - t_last); end
        send_pixels(1, NPIX - 1, -1, 0);
        drain();
        n_checks++; if (st_pulses !== 12 || st_eof_cnt !== 2 || st_mm !== 0) begin n_fail++; $display("FAIL b2b_frames: got %0d pulses %0d eof %0d diffs want 12 2 0", st_pulses, st_eof_cnt, st_mm); end
    endtask

    task automatic test_random();
        clr_stats();
        for (int f = 0; f < 4; f++) begin
            repeat ($urandom_range(0, 2)) drive_cycle(1'b1, 1'b0);
            for (int p = 0; p < NPIX; p++) begin
                drive_cycle(1'b1, p == 0);
                if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) drive_cycle(1'b0, 1'b0);
            end
            drain();
        end
        n_checks++; if (st_mm !== 0) begin n_fail++; $display("FAIL rand_model: %0d cycles differ, first cyc %0d got %h want %h", st_mm, st_mm_cyc, st_mm_got, st_mm_exp); end
        n_checks++; if (st_pulses !== 24 || st_eof_cnt !== 4) begin n_fail++; $display("FAIL rand_pulses: got %0d pulses %0d eof want 24 4", st_pulses, st_eof_cnt); end
    endtask

    initial begin
        clr_stats();
        test_reset();
        test_continuous();
        test_gap();
        test_idle_no_sof();
        test_sof_restart();
        test_reset_in_flush();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/prewitt_frame_ctrl.md
# prewitt_frame_ctrl

Frame sequencer for the 3×3 Prewitt window datapath. It accepts a raster pixel stream, counts column and row, and drives the datapath's `valid_in`. At end of frame it injects flush cycles so the final window results leave the datapath. It also emits an output-valid/SOF/EOF sideband aligned to the datapath's `dout`, marking only interior (fully populated) windows. It sits between the line-buffer write side and the 3×3 matrix stage.

## Interface
- `PIC_WIDTH`, 11'd250: pixels per line; minimum 3.
- `PIC_HEIGHT`, 11'd250: lines per frame; minimum 3.
- `LAT`, 3: datapath latency, counted in `valid_in` edges from window capture to `dout`; minimum 2.
- `clk` input 1: the only clock.
- `rst_n` input 1: asynchronous reset, active-low.
- `pix_valid` input 1: a pixel is present on the line-buffer taps this cycle.
- `pix_sof` input 1: qualifies `pix_valid`; the pixel is (0,0) of a new frame.
- `in_ready` output 1: controller accepts pixels; registered.
- `mat_valid` output 1: drives the datapath `valid_in`; combinational.
- `flush` output 1: datapath muxes zero onto din1..din3; registered.
- `x_cnt` output 11: column of the next accepted pixel.
- `y_cnt` output 11: row of the next accepted pixel.
- `out_valid` output 1: `dout` holds a new interior result this cycle.
- `out_sof` output 1: first interior result of the frame; only with `out_valid`.
- `out_eof` output 1: last interior result of the frame; only with `out_valid`.
- `frame_done` output 1: one-cycle pulse after the flush completes.
- `err_sof` output 1: sticky flag for a SOF arriving mid-frame; cleared only by reset.

## Operation
- Accept = `pix_valid & in_ready`.
- `mat_valid` = accept | (state==FLUSH).
- States and transitions:
  - IDLE: `in_ready`=1; non-SOF pixels are accepted and ignored, with `mat_valid`=0. Accept with `pix_sof` goes to RUN and counts that pixel as (0,0).
  - RUN: each accept advances `x_cnt`. Wrap at PIC_WIDTH-1 to 0 and increment `y_cnt`. The accept at (PIC_WIDTH-1, PIC_HEIGHT-1) goes to FLUSH.
  - FLUSH: `in_ready`=0, `flush`=1, lasts exactly LAT-1 cycles (down-counter), then goes to DONE.
  - DONE: one cycle, `frame_done`=1, `in_ready`=0; then goes to IDLE. Counters reset to 0.
- Tag for each `mat_valid` edge:
  - valid bit = RUN accept & x≥2 & y≥2.
  - sof bit = (x==2 & y==2).
  - eof bit = last pixel.
  - Flush edges carry a zero tag.
- Tag pipeline: LAT stages, shifts only on `mat_valid` edges, and holds on gaps, exactly like the datapath registers.
- `out_valid`/`out_sof`/`out_eof` are registered. Each is set for one cycle after a `mat_valid` edge that loads a tag into stage LAT-1, and equals the corresponding bit of that tag.
- Interior results per frame = (PIC_WIDTH-2)·(PIC_HEIGHT-2).
- SOF in RUN: set `err_sof`, drop the partial frame, restart at (0,0) with that pixel. The tag pipeline is cleared so no stale output is flagged.
- SOF in FLUSH/DONE: not accepted (`in_ready`=0); the source holds it.

## Timing
- Reset values:
  - `in_ready`=1, `flush`=0, `x_cnt`=`y_cnt`=0.
  - `out_valid`=`out_sof`=`out_eof`=0, `frame_done`=0, `err_sof`=0.
  - state=IDLE, tag pipeline=0.
- Latency with continuous input: pixel accepted in cycle t gives `out_valid` in cycle t+LAT.
- Gaps in `pix_valid` stretch latency by the gap length; there is no output between edges.
- Last pixel accepted in cycle T:
  - FLUSH covers T+1..T+LAT-1.
  - `out_eof` appears in cycle T+LAT.
  - `frame_done` appears in cycle T+LAT (DONE), and `in_ready` returns to 1 in cycle T+LAT+1.
- Reset mid-frame: all state returns to the reset values immediately (asynchronous). Any partial output is discarded.

## Structure
- A shared package holds:
  - the state encoding enum (IDLE, RUN, FLUSH, DONE);
  - the tag struct {valid, sof, eof};
  - the counter width constant (11).
- One natural sub-module, `prewitt_tag_pipe`: a LAT-deep, enable-shifted tag shift register with synchronous clear.

## Test plan
- PIC_WIDTH=5, PIC_HEIGHT=4, LAT=3, continuous `pix_valid` with SOF on the first pixel → exactly 6 `out_valid` pulses; `out_sof` on the 1st, `out_eof` on the 6th; 2 `flush` cycles; `frame_done` in cycle T+3.
- Same frame with a 4-cycle `pix_valid` gap after pixel (3,2) → still 6 pulses; no `out_valid` during the gap; following outputs shift by 4 cycles.
- Second SOF at pixel (2,1) → `err_sof`=1 and stays 1; the restarted frame produces 6 pulses; no pulse tagged from the aborted frame.
- Pixels without SOF in IDLE → `mat_valid`=0, counters stay at 0, no outputs.
- `rst_n` low during FLUSH → all outputs go to reset values within the same cycle; the next SOF frame completes normally with 6 pulses.
- `pix_valid` held high with SOF pending during FLUSH/DONE → `in_ready`=0 for 3 cycles; pixel accepted in cycle T+4 starts a new frame.
